pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
Match sequencer for the Pong top level. It sits between the ball/racket datapath and the VGA renderer. It decides when the ball is held at centre, when it moves, and which side serves. It detects points from the ball X coordinate, keeps both scores, and declares a winner.

Parameters:
LEFT_LIMIT, 10, ball_x strictly below this value means a point for player 2
RIGHT_LIMIT, 630, ball_x at or above this value means a point for player 1
WIN_SCORE, 5, score that ends the match (1..15)
SERVE_FRAMES, 60, frame ticks the ball is held at centre before each serve (1..255)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per video frame (start of vertical blanking)
start  input  1  start/restart button, level; already debounced upstream
ball_x  input  10  current ball left-edge X coordinate from the ball datapath
ball_run  output  1  1 = ball datapath may move the ball
ball_center  output  1  1 = ball datapath must hold the ball at screen centre
serve_dir  output  1  direction of the next/current serve: 0 = toward player 1 (left), 1 = toward player 2 (right)
score_p1  output  4  player 1 score
score_p2  output  4  player 2 score
winner  output  2  00 none, 01 player 1, 10 player 2
state  output  2  00 IDLE, 01 SERVE, 10 PLAY, 11 GAME_OVER

Behaviour:
- Single clock domain on clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, ball_run=0, ball_center=1, serve_dir=1, score_p1=0, score_p2=0, winner=00, serve counter=0, start edge register=0.
- start_pulse = start & ~start_q, where start_q is start registered every clock. Holding start produces only one pulse.
- IDLE: ball_run=0, ball_center=1. On start_pulse, go to SERVE next clock: clear both scores, winner=00, serve_dir=1, serve counter=0.
- SERVE: ball_run=0, ball_center=1. Each frame_tick increments the serve counter. The frame_tick that makes the count equal SERVE_FRAMES moves the block to PLAY on the next clock and clears the counter. start_pulse is ignored.
- PLAY: ball_run=1, ball_center=0. ball_x is sampled only on cycles with frame_tick=1.
  - If ball_x < LEFT_LIMIT: score_p2 += 1, serve_dir=0.
  - Else if ball_x >= RIGHT_LIMIT: score_p1 += 1, serve_dir=1.
  - The left check has priority. Only one point is scored per tick.
  - After a point, if the new score equals WIN_SCORE, go to GAME_OVER with winner set to the scorer. Otherwise go to SERVE with the counter at 0.
  - Score, serve_dir, winner and state all update on the same clock edge as the qualifying frame_tick. Latency is 1 clock.
  - A frame_tick with ball_x inside the limits changes nothing.
  - ball_x changes between frame ticks never score.
- GAME_OVER: ball_run=0, ball_center=0 (ball frozen in place). Scores and winner hold. On start_pulse, behave exactly as IDLE on start_pulse.
- ball_run and ball_center are never both 1.
- Scores never exceed WIN_SCORE, so no wrap-around is possible.
- frame_tick and start_pulse in the same cycle: each state acts only on its own trigger as defined above. No conflict arises.
- Reset asserted in any state, including mid-serve countdown or on a scoring tick, wins: all registers take their reset values on that edge.
- state encoding is fixed as listed under Ports. The renderer uses it for overlays.

Test Plan:
- Reset for 2 clocks, then idle 100 clocks -> state=00, ball_center=1, ball_run=0, scores 0/0, winner=00.
- start held high 50 clocks with SERVE_FRAMES=3 -> exactly one transition to SERVE. After the 3rd frame_tick, one clock later: state=10, ball_run=1, ball_center=0.
- In PLAY, drive ball_x=5 then pulse frame_tick -> next clock score_p2=1, serve_dir=0, state=01. Repeat with ball_x=630 after the serve -> score_p1=1, serve_dir=1.
- In PLAY, change ball_x to 0 and then to 300 between frame ticks, with ball_x=300 at the tick -> no score change, state stays 10.
- With WIN_SCORE=2, score two points for player 1 -> state=11, winner=01, ball_run=0, ball_center=0. Further frame_ticks with ball_x=700 do not change the scores. start_pulse -> state=01, scores 0/0, winner=00.
- Assert reset on the same cycle as a scoring frame_tick in PLAY -> next clock state=00, scores 0/0, no point recorded.

Source files
------------

// File: rtl/pong_game_ctrl_if.sv
// Bundle of the signals between the match controller, the ball datapath and the renderer.
// master: the side that drives the frame tick, the start button and the ball position
//         (datapath / testbench) and observes the controller outputs.
// slave:  the match controller itself.
interface pong_game_ctrl_if;
  logic       frame_tick;   // one-cycle pulse per video frame
  logic       start;        // debounced start/restart button level
  logic [9:0] ball_x;       // ball left-edge X coordinate
  logic       ball_run;     // ball may move
  logic       ball_center;  // ball held at screen centre
  logic       serve_dir;    // 0 = serve toward player 1 (left), 1 = toward player 2 (right)
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic [1:0] winner;       // 00 none, 01 player 1, 10 player 2
  logic [1:0] state;        // 00 IDLE, 01 SERVE, 10 PLAY, 11 GAME_OVER

  modport master (
    output frame_tick, start, ball_x,
    input  ball_run, ball_center, serve_dir, score_p1, score_p2, winner, state
  );

  modport slave (
    input  frame_tick, start, ball_x,
    output ball_run, ball_center, serve_dir, score_p1, score_p2, winner, state
  );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: holds the ball at centre for a serve countdown, lets it run, detects
// points from ball_x on frame ticks, keeps both scores and declares the winner.
// Ports:
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - pong_game_ctrl_if.slave: frame_tick/start/ball_x in; ball_run, ball_center,
//           serve_dir, score_p1, score_p2, winner, state out (all registered)
module pong_game_ctrl #(
  parameter int unsigned LEFT_LIMIT   = 10,
  parameter int unsigned RIGHT_LIMIT  = 630,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input logic              clk,
  input logic              reset,
  pong_game_ctrl_if.slave  bus
);

  localparam logic [9:0] LeftLim     = 10'(LEFT_LIMIT);
  localparam logic [9:0] RightLim    = 10'(RIGHT_LIMIT);
  localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
  localparam logic [7:0] ServeFrames = 8'(SERVE_FRAMES);

  // Encoding is visible to the renderer and must not change.
  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StServe    = 2'b01,
    StPlay     = 2'b10,
    StGameOver = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0] winner_q, winner_d;
  logic       dir_q, dir_d;
  logic       run_q, run_d;
  logic       center_q, center_d;
  logic       start_q;
  logic       start_pulse;

  assign start_pulse = bus.start & ~start_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    winner_d = winner_q;
    dir_d    = dir_q;
    unique case (state_q)
      StIdle, StGameOver: begin
        if (start_pulse) begin
          state_d  = StServe;
          cnt_d    = 8'd0;
          p1_d     = 4'd0;
          p2_d     = 4'd0;
          winner_d = 2'b00;
          dir_d    = 1'b1;
        end
      end
      StServe: begin
        if (bus.frame_tick) begin
          if (cnt_q + 8'd1 == ServeFrames) begin
            state_d = StPlay;
            cnt_d   = 8'd0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StPlay: begin
        if (bus.frame_tick) begin
          // Left edge has priority; at most one point per tick.
          if (bus.ball_x < LeftLim) begin
            p2_d  = p2_q + 4'd1;
            dir_d = 1'b0;
            if (p2_d == WinScore) begin
              state_d  = StGameOver;
              winner_d = 2'b10;
            end else begin
              state_d = StServe;
              cnt_d   = 8'd0;
            end
          end else if (bus.ball_x >= RightLim) begin
            p1_d  = p1_q + 4'd1;
            dir_d = 1'b1;
            if (p1_d == WinScore) begin
              state_d  = StGameOver;
              winner_d = 2'b01;
            end else begin
              state_d = StServe;
              cnt_d   = 8'd0;
            end
          end
        end
      end
    endcase
    // Derived from the next state so the registered outputs track state with no lag.
    run_d    = (state_d == StPlay);
    center_d = (state_d == StIdle) || (state_d == StServe);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 8'd0;
      p1_q     <= 4'd0;
      p2_q     <= 4'd0;
      winner_q <= 2'b00;
      dir_q    <= 1'b1;
      run_q    <= 1'b0;
      center_q <= 1'b1;
      start_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      winner_q <= winner_d;
      dir_q    <= dir_d;
      run_q    <= run_d;
      center_q <= center_d;
      start_q  <= bus.start;
    end
  end

  assign bus.state       = state_q;
  assign bus.ball_run    = run_q;
  assign bus.ball_center = center_q;
  assign bus.serve_dir   = dir_q;
  assign bus.score_p1    = p1_q;
  assign bus.score_p2    = p2_q;
  assign bus.winner      = winner_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table, hand sequences for the held-start and
// idle cases, then random stimulus against a behavioural match model.
module tb_pong_game_ctrl;

  localparam int SF  = 3;  // serve frames
  localparam int WS  = 2;  // winning score
  localparam int LL  = 10;
  localparam int RL  = 630;

  logic clk;
  logic reset;
  pong_game_ctrl_if bus ();

  pong_game_ctrl #(
    .LEFT_LIMIT  (LL),
    .RIGHT_LIMIT (RL),
    .WIN_SCORE   (WS),
    .SERVE_FRAMES(SF)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       st;
    logic       tk;
    logic [9:0] bx;
    logic [1:0] e_state;
    logic [1:0] e_win;
    logic [3:0] e_p1;
    logic [3:0] e_p2;
    logic       e_dir;
  } vec_t;

  vec_t vecs[$];

  // Output packing: {state, winner, p1, p2, dir, run, center}
  function automatic logic [14:0] dut_out();
    return {bus.state, bus.winner, bus.score_p1, bus.score_p2, bus.serve_dir, bus.ball_run,
            bus.ball_center};
  endfunction

  function automatic logic [14:0] pack_exp(logic [1:0] s, logic [1:0] w, logic [3:0] a,
                                           logic [3:0] b, logic d);
    logic run, center;
    run    = (s == 2'b10);
    center = (s == 2'b00) || (s == 2'b01);
    return {s, w, a, b, d, run, center};
  endfunction

  task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got st=%b win=%b p1=%0d p2=%0d dir=%b run=%b ctr=%b, expected st=%b win=%b p1=%0d p2=%0d dir=%b run=%b ctr=%b",
               name, act[14:13], act[12:11], act[10:7], act[6:3], act[2], act[1], act[0],
               exp[14:13], exp[12:11], exp[10:7], exp[6:3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic t, input logic [9:0] x);
    reset          = r;
    bus.start      = s;
    bus.frame_tick = t;
    bus.ball_x     = x;
    @(posedge clk);
    #1;
  endtask

  function automatic void add(logic r, logic s, logic t, int x, logic [1:0] es, logic [1:0] ew,
                              int a, int b, logic d);
    vec_t v;
    v.rst = r; v.st = s; v.tk = t; v.bx = 10'(x);
    v.e_state = es; v.e_win = ew; v.e_p1 = 4'(a); v.e_p2 = 4'(b); v.e_dir = d;
    vecs.push_back(v);
  endfunction

  task automatic run_table(input string tag);
    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].st, vecs[i].tk, vecs[i].bx);
      check($sformatf("%s[%0d]", tag, i), dut_out(),
            pack_exp(vecs[i].e_state, vecs[i].e_win, vecs[i].e_p1, vecs[i].e_p2,
                     vecs[i].e_dir));
    end
    vecs.delete();
  endtask

  // Behavioural match model: phase names, a countdown of frames left to hold the ball,
  // scores as plain integers.
  typedef enum int {MIdle, MServe, MPlay, MOver} mphase_e;
  mphase_e m_phase;
  int      m_p1, m_p2, m_win, m_dir, m_hold;
  bit      m_start_prev;

  function automatic void model_step(bit r, bit s, bit t, int x);
    bit pulse;
    if (r) begin
      m_phase = MIdle; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_hold = SF;
      m_start_prev = 0;
      return;
    end
    pulse = s && !m_start_prev;
    m_start_prev = s;
    case (m_phase)
      MIdle, MOver: if (pulse) begin
        m_phase = MServe; m_p1 = 0; m_p2 = 0; m_win = 0; m_dir = 1; m_hold = SF;
      end
      MServe: if (t) begin
        m_hold = m_hold - 1;
        if (m_hold == 0) m_phase = MPlay;
      end
      MPlay: if (t) begin
        int scorer;
        scorer = 0;
        if (x < LL) begin m_p2 = m_p2 + 1; m_dir = 0; scorer = 2; end
        else if (x >= RL) begin m_p1 = m_p1 + 1; m_dir = 1; scorer = 1; end
        if (scorer != 0) begin
          if ((scorer == 1 ? m_p1 : m_p2) == WS) begin
            m_phase = MOver; m_win = scorer;
          end else begin
            m_phase = MServe; m_hold = SF;
          end
        end
      end
      default: ;
    endcase
  endfunction

  function automatic logic [14:0] model_out();
    logic [1:0] s;
    case (m_phase)
      MIdle:   s = 2'b00;
      MServe:  s = 2'b01;
      MPlay:   s = 2'b10;
      default: s = 2'b11;
    endcase
    return pack_exp(s, 2'(m_win), 4'(m_p1), 4'(m_p2), m_dir[0]);
  endfunction

  initial begin
    int transitions;
    logic [1:0] prev_state;
    int pick;
    int bx;
    bit r, s, t;

    reset = 1'b1; bus.start = 1'b0; bus.frame_tick = 1'b0; bus.ball_x = 10'd320;

    // Reset for two clocks.
    add(1, 0, 0, 320, 2'b00, 2'b00, 0, 0, 1);
    add(1, 0, 0, 320, 2'b00, 2'b00, 0, 0, 1);
    run_table("reset");

    // Idle for 100 clocks.
    for (int i = 0; i < 100; i++) begin
      drive(0, 0, 0, 320);
      if (i % 25 == 24)
        check($sformatf("idle[%0d]", i), dut_out(), pack_exp(2'b00, 2'b00, 0, 0, 1'b1));
    end

    // Start held for 50 clocks: exactly one transition into SERVE.
    transitions = 0;
    prev_state  = bus.state;
    for (int i = 0; i < 50; i++) begin
      drive(0, 1, 0, 320);
      if (bus.state != prev_state) transitions++;
      prev_state = bus.state;
    end
    checks++;
    if (transitions != 1) begin
      failures++;
      $display("FAIL start_held_transitions: got %0d expected 1", transitions);
    end
    check("start_held_state", dut_out(), pack_exp(2'b01, 2'b00, 0, 0, 1'b1));

    // Directed match sequence (start released; SERVE with counter at 0).
    add(0, 0, 0, 320, 2'b01, 2'b00, 0, 0, 1);
    add(0, 0, 1, 320, 2'b01, 2'b00, 0, 0, 1);
    add(0, 0, 1, 320, 2'b01, 2'b00, 0, 0, 1);
    add(0, 0, 1, 320, 2'b10, 2'b00, 0, 0, 1);  // third tick -> PLAY
    add(0, 0, 0, 5,   2'b10, 2'b00, 0, 0, 1);  // no tick, no score
    add(0, 0, 1, 5,   2'b01, 2'b00, 0, 1, 0);  // point p2
    add(0, 0, 1, 5,   2'b01, 2'b00, 0, 1, 0);  // ball_x ignored while serving
    add(0, 0, 1, 5,   2'b01, 2'b00, 0, 1, 0);
    add(0, 0, 1, 320, 2'b10, 2'b00, 0, 1, 0);
    add(0, 0, 0, 0,   2'b10, 2'b00, 0, 1, 0);  // out-of-bounds between ticks
    add(0, 0, 1, 300, 2'b10, 2'b00, 0, 1, 0);  // inside at the tick
    add(0, 0, 1, 630, 2'b01, 2'b00, 1, 1, 1);  // point p1
    add(0, 0, 1, 630, 2'b01, 2'b00, 1, 1, 1);
    add(0, 0, 1, 630, 2'b01, 2'b00, 1, 1, 1);
    add(0, 0, 1, 630, 2'b10, 2'b00, 1, 1, 1);
    add(0, 0, 1, 700, 2'b11, 2'b01, 2, 1, 1);  // p1 wins
    add(0, 0, 1, 700, 2'b11, 2'b01, 2, 1, 1);
    add(0, 0, 1, 5,   2'b11, 2'b01, 2, 1, 1);
    add(0, 1, 0, 320, 2'b01, 2'b00, 0, 0, 1);  // restart
    add(0, 1, 1, 320, 2'b01, 2'b00, 0, 0, 1);
    add(0, 0, 1, 320, 2'b01, 2'b00, 0, 0, 1);
    add(0, 0, 1, 320, 2'b10, 2'b00, 0, 0, 1);
    add(0, 0, 1, 10,  2'b10, 2'b00, 0, 0, 1);  // left limit itself is inside
    add(0, 0, 1, 629, 2'b10, 2'b00, 0, 0, 1);  // just below right limit
    add(0, 0, 1, 9,   2'b01, 2'b00, 0, 1, 0);
    add(0, 0, 1, 320, 2'b01, 2'b00, 0, 1, 0);
    add(0, 0, 1, 320, 2'b01, 2'b00, 0, 1, 0);
    add(0, 0, 1, 320, 2'b10, 2'b00, 0, 1, 0);
    add(1, 0, 1, 5,   2'b00, 2'b00, 0, 0, 1);  // reset beats scoring tick
    add(0, 0, 0, 320, 2'b00, 2'b00, 0, 0, 1);
    run_table("vec");

    // Random stimulus against the model.
    s = 0;
    model_step(1, 0, 0, 0);
    drive(1, 0, 0, 320);
    check("rand_reset", dut_out(), model_out());
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 14) == 0) s = ~s;
      t = ($urandom_range(0, 2) == 0);
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: bx = 9;
        1: bx = 10;
        2: bx = 629;
        3: bx = 630;
        4: bx = 0;
        5: bx = 1023;
        default: bx = int'($urandom_range(0, 1023));
      endcase
      model_step(r, s, t, bx);
      drive(r, s, t, 10'(bx));
      check($sformatf("rand[%0d]", i), dut_out(), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
